uart_rxtx_param: RTL and testbench

Parametrised full-duplex UART transceiver. It is the successor to the fixed 8-bit serial datapath behind the top-level wrapper.
- TX takes parallel words over a valid/ready handshake and serialises them.
- RX deserialises, checks, and presents words with a one-cycle valid strobe.
- Generalised in data width, baud divisor, parity mode and stop-bit count; adds error flags and an internal loopback mode.

---
 rtl/uart_rxtx_param.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_uart_rxtx_param.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rxtx_param.sv
// rtl/uart_rxtx_param.sv - parametrised full-duplex UART transceiver with loopback
module uart_rxtx_param #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  input  logic                 rxd,
  input  logic                 loopback,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);

  // Counter is wide enough to time a double stop bit in one run.
  localparam int CW = $clog2(2 * CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);
  localparam logic          PAR_ODD  = (PARITY_ODD != 0);
  localparam logic          PAR_ON   = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------- TX
  state_t                tx_state_q, tx_state_d;
  logic [CW-1:0]         tx_cnt_q, tx_cnt_d;
  logic [3:0]            tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0]  tx_shift_q, tx_shift_d;
  logic                  tx_par_q, tx_par_d;
  logic                  txd_q, txd_d;
  logic                  tx_ready_q, tx_ready_d;

  // TX next state: the line value for the next bit is computed one cycle
  // early so txd is a clean flop output.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    txd_d      = txd_q;
    tx_ready_d = tx_ready_q;
    case (tx_state_q)
      S_IDLE: begin
        txd_d      = 1'b1;
        tx_ready_d = 1'b1;
        if (tx_valid) begin
          tx_shift_d = tx_data;
          tx_par_d   = (^tx_data) ^ PAR_ODD;
          txd_d      = 1'b0;
          tx_ready_d = 1'b0;
          tx_cnt_d   = '0;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
          txd_d      = tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
          tx_state_d = S_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d = '0;
          if (tx_idx_q == LAST_BIT) begin
            if (PAR_ON) begin
              txd_d      = tx_par_q;
              tx_state_d = S_PARITY;
            end else begin
              txd_d      = 1'b1;
              tx_state_d = S_STOP;
            end
          end else begin
            tx_idx_d   = tx_idx_q + 4'd1;
            txd_d      = tx_shift_q[0];
            tx_shift_d = tx_shift_q >> 1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      S_PARITY: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          txd_d      = 1'b1;
          tx_state_d = S_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (tx_cnt_q == STOP_END) begin
          tx_cnt_d   = '0;
          txd_d      = 1'b1;
          tx_ready_d = 1'b1;
          tx_state_d = S_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      default: begin
        tx_cnt_d   = '0;
        txd_d      = 1'b1;
        tx_ready_d = 1'b1;
        tx_state_d = S_IDLE;
      end
    endcase
  end

  // TX state register; reset forces the line high immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      txd_q      <= 1'b1;
      tx_ready_q <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      txd_q      <= txd_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  // ---------------------------------------------------------------- RX
  state_t                rx_state_q, rx_state_d;
  logic [CW-1:0]         rx_cnt_q, rx_cnt_d;
  logic [3:0]            rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0]  rx_shift_q, rx_shift_d;
  logic                  rx_par_q, rx_par_d;
  logic                  rxd_s1_q, rxd_s1_d;
  logic                  rxd_s2_q, rxd_s2_d;
  logic                  rx_prev_q, rx_prev_d;
  logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  rx_perr_q, rx_perr_d;
  logic                  rx_ferr_q, rx_ferr_d;
  logic                  rx_in;

  // Loopback taps the registered txd, which is already in this clock domain.
  assign rx_in = loopback ? txd_q : rxd_s2_q;

  // RX next state: start edge needs a high-to-low transition, so a line
  // stuck low after a framing error cannot retrigger until it goes high.
  always_comb begin
    rxd_s1_d   = rxd;
    rxd_s2_d   = rxd_s1_q;
    rx_prev_d  = rx_in;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    case (rx_state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_in) begin
          rx_cnt_d   = '0;
          rx_state_d = S_START;
        end
      end
      S_START: begin
        if (rx_cnt_q == HALF_END) begin
          rx_cnt_d   = '0;
          rx_idx_d   = '0;
          rx_state_d = rx_in ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_in, rx_shift_q[DATA_BITS-1:1]};
          if (rx_idx_q == LAST_BIT) begin
            rx_state_d = PAR_ON ? S_PARITY : S_STOP;
          end else begin
            rx_idx_d = rx_idx_q + 4'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      S_PARITY: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_par_d   = rx_in;
          rx_state_d = S_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_data_d  = rx_shift_q;
          rx_perr_d  = PAR_ON && (((^rx_shift_q) ^ PAR_ODD) != rx_par_q);
          rx_ferr_d  = !rx_in;
          rx_valid_d = 1'b1;
          rx_state_d = S_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      default: begin
        rx_cnt_d   = '0;
        rx_state_d = S_IDLE;
      end
    endcase
  end

  // RX state register, synchroniser and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rxd_s1_q   <= rxd_s1_d;
      rxd_s2_q   <= rxd_s2_d;
      rx_prev_q  <= rx_prev_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  assign tx_ready      = tx_ready_q;
  assign txd           = txd_q;
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;

endmodule

// File: tb/tb_uart_rxtx_param.sv
// tb/tb_uart_rxtx_param.sv - scoreboard bench for uart_rxtx_param
module tb_uart_rxtx_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: default framing, 8N1
  logic [7:0] a_tx_data = 8'h00;
  logic       a_tx_valid = 1'b0, a_tx_ready, a_txd;
  logic       a_rxd = 1'b1, a_loopback = 1'b0;
  logic [7:0] a_rx_data;
  logic       a_rx_valid, a_pe, a_fe;

  // Instance B: 8E1
  logic [7:0] b_tx_data = 8'h00;
  logic       b_tx_valid = 1'b0, b_tx_ready, b_txd;
  logic       b_rxd = 1'b1, b_loopback = 1'b0;
  logic [7:0] b_rx_data;
  logic       b_rx_valid, b_pe, b_fe;

  uart_rxtx_param u_a (
    .clk(clk), .rst_n(rst_n),
    .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready), .txd(a_txd),
    .rxd(a_rxd), .loopback(a_loopback),
    .rx_data(a_rx_data), .rx_valid(a_rx_valid),
    .rx_parity_err(a_pe), .rx_frame_err(a_fe)
  );

  uart_rxtx_param #(.DATA_BITS(8), .CLKS_PER_BIT(16), .PARITY_EN(1),
                    .PARITY_ODD(0), .STOP_BITS(1)) u_b (
    .clk(clk), .rst_n(rst_n),
    .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready), .txd(b_txd),
    .rxd(b_rxd), .loopback(b_loopback),
    .rx_data(b_rx_data), .rx_valid(b_rx_valid),
    .rx_parity_err(b_pe), .rx_frame_err(b_fe)
  );

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       fe;
    int         tmin;
    int         tmax;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor A: pop expectation on every rx_valid strobe
  exp_t ea;
  logic a_prev_v = 1'b0;
  always @(negedge clk) begin
    if (a_prev_v) chk("a_rx_valid_single", int'(a_rx_valid), 0);
    if (a_rx_valid) begin
      if (qa.size() == 0) chk("a_rx_unexpected", 1, 0);
      else begin
        ea = qa.pop_front();
        chk("a_rx_data", int'(a_rx_data), int'(ea.data));
        chk("a_rx_parity_err", int'(a_pe), int'(ea.pe));
        chk("a_rx_frame_err", int'(a_fe), int'(ea.fe));
        if (ea.tmax > 0) chk("a_rx_latency_ok", int'(cyc >= ea.tmin && cyc <= ea.tmax), 1);
      end
    end
    a_prev_v = a_rx_valid;
  end

  // Monitor B
  exp_t eb;
  logic b_prev_v = 1'b0;
  always @(negedge clk) begin
    if (b_prev_v) chk("b_rx_valid_single", int'(b_rx_valid), 0);
    if (b_rx_valid) begin
      if (qb.size() == 0) chk("b_rx_unexpected", 1, 0);
      else begin
        eb = qb.pop_front();
        chk("b_rx_data", int'(b_rx_data), int'(eb.data));
        chk("b_rx_parity_err", int'(b_pe), int'(eb.pe));
        chk("b_rx_frame_err", int'(b_fe), int'(eb.fe));
        if (eb.tmax > 0) chk("b_rx_latency_ok", int'(cyc >= eb.tmin && cyc <= eb.tmax), 1);
      end
    end
    b_prev_v = b_rx_valid;
  end

  // Present a word for one cycle; returns the cycle stamp of the accept edge.
  task automatic tx_send(input bit sel_b, input logic [7:0] d, output int acc);
    @(negedge clk);
    if (sel_b) begin b_tx_data = d; b_tx_valid = 1'b1; end
    else       begin a_tx_data = d; a_tx_valid = 1'b1; end
    @(negedge clk);
    acc = cyc;
    a_tx_valid = 1'b0;
    b_tx_valid = 1'b0;
  endtask

  task automatic drive_bit(input bit sel_b, input logic v, input int n);
    if (sel_b) b_rxd = v; else a_rxd = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic rx_frame(input bit sel_b, input logic [7:0] d, input bit par_en,
                          input logic par, input logic stop, input int stop_len);
    drive_bit(sel_b, 1'b0, 16);
    for (int i = 0; i < 8; i++) drive_bit(sel_b, d[i], 16);
    if (par_en) drive_bit(sel_b, par, 16);
    drive_bit(sel_b, stop, stop_len);
    drive_bit(sel_b, 1'b1, 32);
  endtask

  int         acc;
  int         low_cnt;
  logic [9:0] fr;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_txd", int'(a_txd), 1);
    chk("rst_tx_ready", int'(a_tx_ready), 1);
    chk("rst_rx_valid", int'(a_rx_valid), 0);
    chk("rst_rx_data", int'(a_rx_data), 0);
    chk("rst_parity_err", int'(a_pe), 0);
    chk("rst_frame_err", int'(a_fe), 0);
    chk("rst_b_txd", int'(b_txd), 1);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // TX waveform of 0xA5, with mid-frame data change and ignored tx_valid
    fr = {1'b1, 8'hA5, 1'b0};
    low_cnt = 0;
    tx_send(1'b0, 8'hA5, acc);
    a_tx_data = 8'h00;
    for (int c = 0; c < 176; c++) begin
      if (!a_tx_ready) low_cnt++;
      if (c % 16 == 8 && c < 160) chk($sformatf("tx_bit%0d", c / 16), int'(a_txd), int'(fr[c / 16]));
      if (c == 50) begin a_tx_data = 8'hFF; a_tx_valid = 1'b1; end
      if (c == 51) a_tx_valid = 1'b0;
      @(negedge clk);
    end
    chk("tx_ready_low_cycles", low_cnt, 160);
    chk("tx_idle_txd", int'(a_txd), 1);
    chk("tx_idle_ready", int'(a_tx_ready), 1);

    // Loopback 0x3C with latency window
    a_loopback = 1'b1;
    tx_send(1'b0, 8'h3C, acc);
    qa.push_back('{8'h3C, 1'b0, 1'b0, acc + 152, acc + 154});
    repeat (200) @(negedge clk);
    a_loopback = 1'b0;
    repeat (4) @(negedge clk);

    // Framing error with line held low afterwards, then clean frame
    qa.push_back('{8'h55, 1'b0, 1'b1, 0, 0});
    rx_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 56);
    qa.push_back('{8'h12, 1'b0, 1'b0, 0, 0});
    rx_frame(1'b0, 8'h12, 1'b0, 1'b0, 1'b1, 16);

    // Short glitch rejected, then 0x81
    drive_bit(1'b0, 1'b0, 3);
    drive_bit(1'b0, 1'b1, 40);
    qa.push_back('{8'h81, 1'b0, 1'b0, 0, 0});
    rx_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1, 16);

    // Even parity on B: 0x07 needs parity bit 1
    qb.push_back('{8'h07, 1'b1, 1'b0, 0, 0});
    rx_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1, 16);
    qb.push_back('{8'h07, 1'b0, 1'b0, 0, 0});
    rx_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 16);

    // B parity generator through loopback
    b_loopback = 1'b1;
    tx_send(1'b1, 8'h07, acc);
    qb.push_back('{8'h07, 1'b0, 1'b0, acc + 168, acc + 170});
    repeat (200) @(negedge clk);
    tx_send(1'b1, 8'h03, acc);
    qb.push_back('{8'h03, 1'b0, 1'b0, acc + 168, acc + 170});
    repeat (200) @(negedge clk);
    b_loopback = 1'b0;

    // Reset during bit 4 of a TX frame
    tx_send(1'b0, 8'h5A, acc);
    repeat (72) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_txd", int'(a_txd), 1);
    chk("midrst_tx_ready", int'(a_tx_ready), 1);
    @(negedge clk);
    chk("midrst_rx_data", int'(a_rx_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    a_loopback = 1'b1;
    tx_send(1'b0, 8'hC3, acc);
    qa.push_back('{8'hC3, 1'b0, 1'b0, acc + 152, acc + 154});
    repeat (200) @(negedge clk);

    // Drain with a bounded wait
    for (int i = 0; i < 500; i++) begin
      if (qa.size() == 0 && qb.size() == 0) break;
      @(negedge clk);
    end
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
